// File: rtl/uart_echo_pkg.sv
`default_nettype none
// ============================================================================
// uart_echo_pkg : shared state encodings and helpers for uart_echo_fifo
// Rev 1.0
// ============================================================================
package uart_echo_pkg;

  // Bit-period divisor that places the start-bit sample mid-bit.
  localparam int HALF_BIT_DIV = 2;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_ECHO_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_ECHO_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_t;

  // Even parity over up to 9 data bits; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [8:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_echo_fifo_if.sv
`default_nettype none
// ============================================================================
// uart_echo_fifo_if : pin/status bundle between board-side logic and the echo
// Rev 1.0
// ============================================================================
interface uart_echo_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  logic                          echo_en;
  logic                          rxd;
  logic                          txd;
  logic [DATA_BITS-1:0]          word;
  logic                          rx_valid;
  logic                          tx_busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          frame_err;

  modport master (
    output echo_en, rxd,
    input  txd, word, rx_valid, tx_busy, fifo_count, overflow, frame_err
  );

  modport slave (
    input  echo_en, rxd,
    output txd, word, rx_valid, tx_busy, fifo_count, overflow, frame_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_echo_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO, power-of-two depth, registered read on pop
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      used;
  logic             do_pop;
  logic             do_push;

  assign full    = (used == (AW+1)'(DEPTH));
  assign empty   = (used == '0);
  assign count   = used;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so push on full still succeeds.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      used     <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        pop_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// uart_echo_fifo : buffered UART echo (RX -> FIFO -> TX) with framing checks;
// define UART_ECHO_PARITY_EN for an even-parity bit on both directions.
// Rev 1.0
// ============================================================================
module uart_echo_fifo
  import uart_echo_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_echo_fifo_if.slave bus
);
  localparam int CW   = $clog2(BAUD_DIV);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int NW   = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF = BAUD_DIV / HALF_BIT_DIV;

  logic                 rxd_meta;
  logic                 rxd_sync;
  rx_state_t            rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] rx_word;
  logic                 rx_pulse;
  logic                 err_pulse;
  logic                 push_req;
  logic                 stop_ok;
`ifdef UART_ECHO_PARITY_EN
  logic                 parity_bad;
`endif

  tx_state_t            tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_line;
  logic                 tx_active;
`ifdef UART_ECHO_PARITY_EN
  logic                 tx_par;
`endif

  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [NW-1:0]        fifo_count;
  logic                 ovf;

`ifdef UART_ECHO_PARITY_EN
  assign stop_ok = rxd_sync && !parity_bad;
`else
  assign stop_ok = rxd_sync;
`endif

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_word   <= '0;
      rx_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      push_req  <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      rxd_meta  <= bus.rxd;
      rxd_sync  <= rxd_meta;
      rx_pulse  <= 1'b0;
      err_pulse <= 1'b0;
      push_req  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rxd_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(BAUD_DIV - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_ECHO_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`ifdef UART_ECHO_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt == CW'(BAUD_DIV - 1)) begin
            rx_cnt     <= '0;
            parity_bad <= (rxd_sync != even_parity(9'(rx_shift)));
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
`endif
        RX_STOP: begin
          if (rx_cnt == CW'(BAUD_DIV - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (stop_ok) begin
              rx_word  <= rx_shift;
              rx_pulse <= 1'b1;
              push_req <= 1'b1;
            end else begin
              err_pulse <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Buffer; rx_word holds the pushed byte during the push cycle.
  // --------------------------------------------------------------------------
  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (rx_word),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst)                                  ovf <= 1'b0;
    else if (push_req && fifo_full && !pop)   ovf <= 1'b1;
  end

  // --------------------------------------------------------------------------
  // Transmitter; echo_en is only consulted in IDLE so a frame always completes.
  // --------------------------------------------------------------------------
  assign pop = (tx_state == TX_IDLE) && bus.echo_en && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_line   <= 1'b1;
      tx_active <= 1'b0;
`ifdef UART_ECHO_PARITY_EN
      tx_par    <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_line <= 1'b1;
          tx_cnt  <= '0;
          if (pop) begin
            tx_state  <= TX_START;
            tx_line   <= 1'b0;
            tx_active <= 1'b1;
          end
        end
        TX_START: begin
          if (tx_cnt == CW'(BAUD_DIV - 1)) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= fifo_rdata;
            tx_line  <= fifo_rdata[0];
`ifdef UART_ECHO_PARITY_EN
            tx_par   <= even_parity(9'(fifo_rdata));
`endif
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CW'(BAUD_DIV - 1)) begin
            tx_cnt <= '0;
            if (tx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_ECHO_PARITY_EN
              tx_state <= TX_PARITY;
              tx_line  <= tx_par;
`else
              tx_state <= TX_STOP;
              tx_line  <= 1'b1;
`endif
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= tx_shift >> 1;
              tx_line  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`ifdef UART_ECHO_PARITY_EN
        TX_PARITY: begin
          if (tx_cnt == CW'(BAUD_DIV - 1)) begin
            tx_cnt   <= '0;
            tx_line  <= 1'b1;
            tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (tx_cnt == CW'(BAUD_DIV - 1)) begin
            tx_cnt    <= '0;
            tx_active <= 1'b0;
            tx_state  <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign bus.txd        = tx_line;
  assign bus.word       = rx_word;
  assign bus.rx_valid   = rx_pulse;
  assign bus.tx_busy    = tx_active;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = ovf;
  assign bus.frame_err  = err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_uart_echo_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_echo_fifo : directed self-checking bench for uart_echo_fifo
// Rev 1.0
// ============================================================================
module tb_uart_echo_fifo;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  int   rxv_cnt = 0;
  int   rxv_cyc = 0;
  int   ferr_cnt = 0;
  int   busy_run = 0;
  int   last_busy = 0;
  logic last_stop = 1'b0;
  logic last_par = 1'b0;
  logic [7:0] tx_q[$];
  int         fall_q[$];

  uart_echo_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus();

  uart_echo_fifo #(
    .BAUD_DIV   (BD),
    .DATA_BITS  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rxv_cnt++;
      rxv_cyc = cyc;
    end
    if (bus.frame_err) ferr_cnt++;
    if (bus.tx_busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
  end

  // Serial decoder on txd: samples mid-bit after each detected start edge.
  initial begin : tx_mon
    logic [7:0] b;
    b = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.txd == 1'b0) begin
        fall_q.push_back(cyc);
        repeat (BD/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = bus.txd;
        end
`ifdef UART_ECHO_PARITY_EN
        repeat (BD) @(negedge clk);
        last_par = bus.txd;
`endif
        repeat (BD) @(negedge clk);
        last_stop = bus.txd;
        tx_q.push_back(b);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    bus.rxd = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      repeat (BD) @(negedge clk);
    end
`ifdef UART_ECHO_PARITY_EN
    bus.rxd = par_bit;
    repeat (BD) @(negedge clk);
`endif
    bus.rxd = stop_bit;
    repeat (BD) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (BD) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    int t;
    t = 0;
    while (tx_q.size() < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check_eq("tx_frames_seen", tx_q.size(), n);
  endtask

  initial begin : main
    int base_rxv;
    int base_ferr;
    int base_tx;
    int t;

    bus.rxd     = 1'b1;
    bus.echo_en = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_txd",        bus.txd, 1);
    check_eq("rst_word",       bus.word, 0);
    check_eq("rst_rx_valid",   bus.rx_valid, 0);
    check_eq("rst_tx_busy",    bus.tx_busy, 0);
    check_eq("rst_fifo_count", bus.fifo_count, 0);
    check_eq("rst_overflow",   bus.overflow, 0);
    check_eq("rst_frame_err",  bus.frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single good frame and its echo
    base_rxv = rxv_cnt;
    send_byte(8'hA5, 1'b1, 1'b0);
    wait_tx(1);
    repeat (10) @(negedge clk);
    check_eq("a5_rx_valid_pulses", rxv_cnt - base_rxv, 1);
    check_eq("a5_word",            bus.word, 8'hA5);
    check_eq("a5_echo_byte",       tx_q[0], 8'hA5);
    check_eq("a5_fall_latency",    fall_q[0] - rxv_cyc, 2);
    check_eq("a5_busy_len",        last_busy, 80);
    check_eq("a5_stop_bit",        last_stop, 1);
    check_eq("a5_no_frame_err",    ferr_cnt, 0);

    // Bad stop bit
    base_rxv = rxv_cnt;
    base_tx  = tx_q.size();
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    check_eq("3c_frame_err_pulses", ferr_cnt, 1);
    check_eq("3c_no_rx_valid",      rxv_cnt - base_rxv, 0);
    check_eq("3c_word_kept",        bus.word, 8'hA5);
    check_eq("3c_fifo_count",       bus.fifo_count, 0);
    check_eq("3c_no_echo",          tx_q.size(), base_tx);
    check_eq("3c_txd_idle",         bus.txd, 1);

    // Paused echo, overflow, then ordered drain
    bus.echo_en = 1'b0;
    base_rxv = rxv_cnt;
    base_tx  = tx_q.size();
    for (int k = 1; k <= 6; k++) send_byte(8'(k), 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("ovf_rx_valid_pulses", rxv_cnt - base_rxv, 6);
    check_eq("ovf_fifo_count",      bus.fifo_count, 4);
    check_eq("ovf_overflow",        bus.overflow, 1);
    check_eq("ovf_no_echo",         tx_q.size(), base_tx);
    check_eq("ovf_word_last",       bus.word, 8'h06);
    bus.echo_en = 1'b1;
    wait_tx(base_tx + 4);
    repeat (200) @(negedge clk);
    check_eq("drain_frames",  tx_q.size(), base_tx + 4);
    for (int k = 0; k < 4; k++)
      check_eq("drain_byte", tx_q[base_tx + k], 32'(k + 1));
    check_eq("drain_b2b_gap", fall_q[base_tx + 1] - fall_q[base_tx], 81);
    check_eq("drain_empty",   bus.fifo_count, 0);

    // Short low glitch on idle line, then a good frame still decodes
    base_rxv  = rxv_cnt;
    base_ferr = ferr_cnt;
    bus.rxd = 1'b0;
    repeat (3) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("glitch_no_rx_valid",  rxv_cnt - base_rxv, 0);
    check_eq("glitch_no_frame_err", ferr_cnt - base_ferr, 0);
    base_tx = tx_q.size();
    send_byte(8'h5A, 1'b1, 1'b0);
    wait_tx(base_tx + 1);
    check_eq("glitch_next_word", bus.word, 8'h5A);
    check_eq("glitch_next_echo", tx_q[base_tx], 8'h5A);
    repeat (20) @(negedge clk);

    // Reset in the middle of a transmitted frame
    send_byte(8'h96, 1'b1, 1'b0);
    t = 0;
    while (!bus.tx_busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    check_eq("mid_tx_busy",     bus.tx_busy, 1);
    check_eq("mid_ovf_sticky",  bus.overflow, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_txd",        bus.txd, 1);
    check_eq("rst_mid_fifo_count", bus.fifo_count, 0);
    check_eq("rst_mid_overflow",   bus.overflow, 0);
    check_eq("rst_mid_tx_busy",    bus.tx_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    tx_q.delete();
    fall_q.delete();

`ifdef UART_ECHO_PARITY_EN
    // 0x07 has three ones, so even parity is 1
    base_ferr = ferr_cnt;
    send_byte(8'h07, 1'b1, 1'b0);
    repeat (100) @(negedge clk);
    check_eq("par_bad_frame_err", ferr_cnt - base_ferr, 1);
    check_eq("par_bad_no_echo",   tx_q.size(), 0);
    send_byte(8'h07, 1'b1, 1'b1);
    wait_tx(1);
    check_eq("par_good_echo", tx_q[0], 8'h07);
    check_eq("par_good_bit",  last_par, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Buffered, parametrised UART echo block: receives serial frames on `rxd`, stores good bytes in a FIFO, and retransmits them on `txd`. It replaces the unbuffered single-word echo path. A back-to-back burst no longer overwrites the word in flight. Framing errors are detected and reported. Echo can be paused while input keeps being buffered. It sits between the board UART pins and the status LEDs/switches.

## Interface
- `BAUD_DIV`, default 434: clock cycles per bit (≥4).
- `DATA_BITS`, default 8: data bits per frame, 5–9.
- `FIFO_DEPTH`, default 16: FIFO entries, power of two, ≥2.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `echo_en` in 1: 1 lets TX pop the FIFO; 0 pauses TX after the current frame; RX keeps filling.
- `rxd` in 1: serial input, idle high, asynchronous.
- `txd` out 1: serial output, idle high.
- `word` out DATA_BITS: last good received byte.
- `rx_valid` out 1: one-cycle pulse when `word` updates.
- `tx_busy` out 1: high while a frame is being driven on `txd`.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` out 1: sticky; set when a good byte is dropped on full FIFO.
- `frame_err` out 1: one-cycle pulse on a bad stop bit (or parity, see Configuration).

## Operation
- `rxd` passes through a 2-flop synchronizer before use.
- RX FSM states are IDLE, START, DATA, STOP (plus PARITY if enabled).
  - IDLE → START on synchronized falling level.
  - START: the line is resampled at BAUD_DIV/2. If it is high, the block treats it as a glitch and returns to IDLE; if it is low, the block goes to DATA.
  - DATA: DATA_BITS samples, one every BAUD_DIV, LSB first, shifted into a shift register.
  - STOP: the line is sampled once. If it is 1, the frame is good: `word` loads, `rx_valid` pulses, and a FIFO push is requested. If it is 0, the byte is discarded and `frame_err` pulses. Either way the FSM returns to IDLE.
- FIFO behaviour:
  - A push on full drops the byte and sets `overflow` (it stays set until `rst`). `rx_valid` still pulses.
  - Simultaneous push and pop on full succeeds, and the count is unchanged.
  - Pop on empty never occurs.
- TX FSM states are IDLE, START, DATA, STOP.
  - IDLE with `echo_en`=1 and FIFO non-empty: pop, latch the byte, go to START.
  - Each state holds for BAUD_DIV cycles, driving 0, the data bits LSB first, then 1.
  - STOP → IDLE.
  - `echo_en` falling mid-frame does not truncate the frame.
- Reset values:
  - `txd`=1.
  - `word`=0, `rx_valid`=0, `tx_busy`=0, `fifo_count`=0, `overflow`=0, `frame_err`=0.
  - Both FSMs return to IDLE and the FIFO empties.
  - `rst` mid-frame aborts both frames immediately, and `txd` returns to 1 the next cycle.

## Timing
- RX sample points: the start bit at BAUD_DIV/2 after the detected edge, then every BAUD_DIV.
- `rx_valid`/`frame_err` are registered and assert the cycle after the stop sample (cycle P).
- Push occurs at P, and `fifo_count` reflects it at P+1.
- With TX idle and `echo_en`=1, the pop happens at P+1 and `txd` falls at P+2.
- TX frame length is exactly (DATA_BITS+2)·BAUD_DIV cycles, or +BAUD_DIV with parity.
- `tx_busy` is high from the `txd` fall through the last stop cycle.
- Back-to-back TX: the next START begins one cycle after STOP ends when the FIFO is non-empty (one-cycle IDLE for the pop).

## Configuration
- `UART_ECHO_PARITY_EN` defined:
  - RX expects, and TX appends, an even-parity bit after the data bits.
  - An RX parity mismatch discards the byte and pulses `frame_err`. It uses the same timing as a stop error, and the stop bit is still sampled.
- Undefined: no parity state, and frames are 8N1-style with DATA_BITS data bits.

## Structure
- Package `uart_echo_pkg` holds:
  - `rx_state_t`/`tx_state_t` enums;
  - the `even_parity` function;
  - the constant for the half-bit point.
- Sub-module `sync_fifo`:
  - parameters WIDTH and DEPTH;
  - push/pop/full/empty/count;
  - read data registered on pop.
- The RX and TX FSMs live in the top.

## Test plan
Bench parameters: BAUD_DIV=8, DATA_BITS=8, FIFO_DEPTH=4, `echo_en`=1 unless stated.
- Single frame 0xA5 on `rxd`:
  - `word`=0xA5 with one `rx_valid` pulse;
  - `txd` falls 2 cycles later;
  - serial 0xA5 reappears, 80 cycles long.
- 0x3C sent with stop bit 0:
  - `frame_err` pulses once;
  - `word` and `fifo_count` are unchanged;
  - `txd` stays 1.
- `echo_en`=0, send 0x01..0x06:
  - `fifo_count` reaches 4 and `overflow`=1;
  - raising `echo_en` echoes exactly 0x01..0x04 in order.
- 3-cycle low glitch on idle `rxd` → no `rx_valid`, no `frame_err`, RX back in IDLE.
- `rst` asserted mid-TX frame → next cycle `txd`=1, `fifo_count`=0, `overflow`=0.
- With `UART_ECHO_PARITY_EN` defined, 0x07 with wrong parity → `frame_err` pulse, no echo; correct parity → echoed with parity bit 1.
